cubic_bisect: RTL and testbench

Root-finding controller for the cubic evaluator. Given monic cubic coefficients and a bracketing interval [lo, hi], it drives the evaluator's x/coefficient inputs and reads back y. It then narrows the interval by bisection for a fixed number of iterations and reports the root in Q(WID, FBITS). It sits beside the pipelined cubic evaluator: upstream of its inputs and downstream of its output, with an FSM that accounts for the evaluator's pipeline latency.

---
 rtl/cubic_bisect.sv | 204 ++++++++++++++++++++
 tb/tb_cubic_bisect.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cubic_bisect.sv
// cubic_bisect: bisection root finder wrapped around an external pipelined
// cubic evaluator. It captures a monic cubic and a bracket [lo, hi], then
// evaluates f(lo), f(hi) and ITERS midpoints. The bracket is narrowed on the
// sign of each result, and the final midpoint (or an exact zero) is reported
// in signed Q(WID, FBITS).
module cubic_bisect #(
  parameter int WID   = 16,
  parameter int FBITS = 8,
  parameter int ITERS = 16,
  parameter int LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic signed [WID-1:0] a0,
  input  logic signed [WID-1:0] a1,
  input  logic signed [WID-1:0] a2,
  input  logic signed [WID-1:0] lo,
  input  logic signed [WID-1:0] hi,
  output logic signed [WID-1:0] ev_x,
  output logic signed [WID-1:0] ev_a0,
  output logic signed [WID-1:0] ev_a1,
  output logic signed [WID-1:0] ev_a2,
  input  logic signed [WID-1:0] ev_y,
  output logic                  busy,
  output logic                  done,
  output logic signed [WID-1:0] root,
  output logic                  fail
);

  // Midpoint counter saturates at ITERS. The wait counter runs 0..LAT,
  // so it spans LAT+1 edges.
  localparam int CW = $clog2(ITERS + 1);
  localparam int WW = $clog2(LAT + 2);
  localparam logic [CW-1:0] ITERS_C    = CW'(ITERS);
  localparam logic [CW-1:0] ITERS_LAST = CW'(ITERS - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(LAT);

  // Reject parameter sets the datapath cannot honour.
  if (ITERS < 1 || LAT < 0 || FBITS >= WID) begin : g_param_check
    $error("cubic_bisect: invalid parameters");
  end

  // The issue edge is the edge leaving IDLE or UPDATE; it writes ev_x and
  // enters WAIT. The last WAIT edge is the sample edge, where the decision
  // is taken.
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_UPDATE
  } state_t;

  // Selects which evaluation the pending ev_y belongs to.
  typedef enum logic [1:0] {
    PH_LO,
    PH_HI,
    PH_MID
  } phase_t;

  state_t                state;
  phase_t                phase;
  logic [WW-1:0]         wait_cnt;
  logic [CW-1:0]         mid_cnt;
  logic signed [WID-1:0] lo_r;
  logic signed [WID-1:0] hi_r;
  logic                  sgn_lo;

  logic signed [WID:0]   diff;
  logic signed [WID-1:0] mid;
  logic                  mid_unused_carry;
  logic                  y_zero;
  logic                  y_neg;

  // Midpoint of the current bracket. The difference is formed one bit wider,
  // so hi_r - lo_r cannot wrap. lo_r + diff/2 always lies inside the bracket,
  // so the extra top bit of the sum is only a sign copy and is dropped.
  always_comb begin
    diff = {hi_r[WID-1], hi_r} - {lo_r[WID-1], lo_r};
    {mid_unused_carry, mid} = {lo_r[WID-1], lo_r} + (diff >>> 1);
  end

  assign y_zero = (ev_y == '0);
  assign y_neg  = ev_y[WID-1];

  // Controller FSM; all outputs are registered here.
  // NOTE: every register below uses non-blocking assignments so all
  // decisions on an edge see the pre-edge values of lo_r, hi_r and ev_x.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      phase    <= PH_LO;
      wait_cnt <= '0;
      mid_cnt  <= '0;
      lo_r     <= '0;
      hi_r     <= '0;
      sgn_lo   <= 1'b0;
      ev_x     <= '0;
      ev_a0    <= '0;
      ev_a1    <= '0;
      ev_a2    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      root     <= '0;
      fail     <= 1'b0;
    end else begin
      // NOTE: done is defaulted low every cycle, which makes it a one-cycle
      // pulse without any extra clear logic.
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            ev_a0    <= a0;
            ev_a1    <= a1;
            ev_a2    <= a2;
            lo_r     <= lo;
            hi_r     <= hi;
            phase    <= PH_LO;
            mid_cnt  <= '0;
            wait_cnt <= '0;
            if (lo >= hi) begin
              // Empty bracket: report failure at once, with no evaluation.
              done <= 1'b1;
              fail <= 1'b1;
              root <= '0;
              busy <= 1'b0;
            end else begin
              ev_x  <= lo;
              busy  <= 1'b1;
              state <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (wait_cnt != WAIT_LAST) begin
            wait_cnt <= wait_cnt + WW'(1);
          end else begin
            wait_cnt <= '0;
            state    <= S_UPDATE;
            case (phase)
              PH_LO: begin
                if (y_zero) begin
                  root  <= lo_r;
                  fail  <= 1'b0;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
                end else begin
                  sgn_lo <= y_neg;
                  phase  <= PH_HI;
                end
              end
              PH_HI: begin
                if (y_zero) begin
                  root  <= hi_r;
                  fail  <= 1'b0;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
                end else if (y_neg == sgn_lo) begin
                  // No sign change across the bracket.
                  root  <= '0;
                  fail  <= 1'b1;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
                end else begin
                  phase <= PH_MID;
                end
              end
              default: begin
                // ev_x still holds the midpoint that produced this ev_y.
                if (y_neg == sgn_lo) begin
                  lo_r <= ev_x;
                end else begin
                  hi_r <= ev_x;
                end
                if (mid_cnt != ITERS_C) begin
                  mid_cnt <= mid_cnt + CW'(1);
                end
                if (y_zero || mid_cnt == ITERS_LAST) begin
                  root  <= ev_x;
                  fail  <= 1'b0;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
                end
              end
            endcase
          end
        end

        S_UPDATE: begin
          // mid reflects the freshly narrowed bracket; this edge issues it.
          ev_x  <= (phase == PH_HI) ? hi_r : mid;
          state <= S_WAIT;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cubic_bisect.sv
// Testbench for cubic_bisect. It includes a behavioural model of the
// LAT-stage cubic evaluator. Each run's expected root, fail flag and
// completion cycle are computed from a plain bisection model and pushed into
// a scoreboard. A monitor pops and compares on every done pulse.
module tb_cubic_bisect;

  localparam int WID   = 16;
  localparam int FBITS = 8;
  localparam int ITERS = 16;
  localparam int LAT   = 2;
  localparam int SLOT  = LAT + 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic signed [WID-1:0] a0, a1, a2, lo, hi;
  logic signed [WID-1:0] ev_x, ev_a0, ev_a1, ev_a2, ev_y;
  logic signed [WID-1:0] root;
  logic                  busy, done, fail;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int root;
    bit fail;
    int done_cyc;
  } exp_t;

  exp_t sb[$];

  cubic_bisect #(.WID(WID), .FBITS(FBITS), .ITERS(ITERS), .LAT(LAT)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a0    (a0),
    .a1    (a1),
    .a2    (a2),
    .lo    (lo),
    .hi    (hi),
    .ev_x  (ev_x),
    .ev_a0 (ev_a0),
    .ev_a1 (ev_a1),
    .ev_a2 (ev_a2),
    .ev_y  (ev_y),
    .busy  (busy),
    .done  (done),
    .root  (root),
    .fail  (fail)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monic cubic f(x) = x^3 + a2 x^2 + a1 x + a0 in Q8.8, saturated to 16 bits.
  function automatic int f_eval(input int x, input int c0, input int c1, input int c2);
    longint xx, acc, y;
    xx  = x;
    acc = xx * xx * xx + longint'(c2) * xx * xx + longint'(c1) * xx * 256
        + longint'(c0) * 65536;
    y   = acc >>> 16;
    if (y > 32767)  y = 32767;
    if (y < -32768) y = -32768;
    return int'(y);
  endfunction

  // Evaluator pipeline: result appears LAT edges after ev_x changes.
  logic signed [WID-1:0] ev_p1;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_p1 <= '0;
      ev_y  <= '0;
    end else begin
      ev_p1 <= WID'(f_eval(int'(ev_x), int'(ev_a0), int'(ev_a1), int'(ev_a2)));
      ev_y  <= ev_p1;
    end
  end

  // Reference bisection: returns the root, the fail flag and the number of
  // evaluations issued (0 for an empty bracket).
  task automatic ref_run(input int c0, input int c1, input int c2,
                         input int l_in, input int h_in,
                         output int r, output bit fl, output int n);
    int l, h, m, y;
    bit s;
    l = l_in; h = h_in; r = 0; fl = 1'b0; n = 0;
    if (l >= h) begin
      fl = 1'b1;
      return;
    end
    n = 1;
    y = f_eval(l, c0, c1, c2);
    if (y == 0) begin r = l; return; end
    s = (y < 0);
    n = 2;
    y = f_eval(h, c0, c1, c2);
    if (y == 0) begin r = h; return; end
    if ((y < 0) == s) begin fl = 1'b1; return; end
    for (int k = 1; k <= ITERS; k++) begin
      m = l + (h - l) / 2;
      n = 2 + k;
      y = f_eval(m, c0, c1, c2);
      if (y == 0) begin r = m; return; end
      if ((y < 0) == s) l = m; else h = m;
      if (k == ITERS) r = m;
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", int'(done), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("root", int'(root), e.root);
        check("fail", int'(fail), int'(e.fail));
        check("done_cycle", cyc, e.done_cyc);
        check("busy_at_done", int'(busy), 0);
      end
    end
  end

  // Called at a negedge: presents a start, waits past E0, drops start.
  task automatic launch(input int c0, input int c1, input int c2,
                        input int l, input int h, input bit expect_done);
    int r, n;
    bit fl;
    exp_t e;
    a0 = WID'(c0); a1 = WID'(c1); a2 = WID'(c2); lo = WID'(l); hi = WID'(h);
    start = 1'b1;
    if (expect_done) begin
      ref_run(c0, c1, c2, l, h, r, fl, n);
      e.root     = r;
      e.fail     = fl;
      e.done_cyc = (cyc + 1) + ((n == 0) ? 0 : n * SLOT - 1);
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge where done is high, counting busy cycles before it.
  task automatic wait_done(output int busy_cycles);
    int timed_out;
    busy_cycles = 0;
    timed_out   = 1;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        timed_out = 0;
        break;
      end
      if (busy) busy_cycles++;
      @(negedge clk);
    end
    check("done_timeout", timed_out, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int c0, c1, c2, l, h;
    rst = 1'b1; start = 1'b0;
    a0 = '0; a1 = '0; a2 = '0; lo = '0; hi = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_root", int'(root), 0);
    check("reset_fail", int'(fail), 0);
    check("reset_ev_x", int'(ev_x), 0);
    rst = 1'b0;
    @(negedge clk);

    // x^3 - 2 over [0, 2]: full run, followed by back-to-back starts.
    launch(-512, 0, 0, 0, 512, 1'b1);
    wait_done(bc);
    check("cbrt2_busy_cycles", bc, 71);
    check("cbrt2_root_range", int'(root == 322 || root == 323), 1);
    launch(-256, 0, 0, 0, 512, 1'b1);   // starts on the cycle after done
    wait_done(bc);
    check("cube1_root", int'(root), 256);
    launch(0, 0, 0, 0, 256, 1'b1);      // f(lo) == 0
    wait_done(bc);
    launch(256, 0, 0, 0, 512, 1'b1);    // no sign change
    wait_done(bc);
    check("same_sign_fail", int'(fail), 1);
    launch(0, 0, 0, 100, 100, 1'b1);    // empty bracket
    wait_done(bc);
    check("empty_bracket_busy", bc, 0);
    @(negedge clk);

    // Abort by reset mid-run, then rerun normally.
    launch(-512, 0, 0, 0, 512, 1'b0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_root", int'(root), 0);
    check("abort_fail", int'(fail), 0);
    check("abort_ev_x", int'(ev_x), 0);
    check("abort_ev_a0", int'(ev_a0), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    launch(-512, 0, 0, 0, 512, 1'b1);
    wait_done(bc);
    @(negedge clk);

    // A start while busy is ignored.
    launch(-512, 0, 0, 0, 512, 1'b1);
    repeat (4) @(negedge clk);
    launch(-256, 100, 0, -256, 256, 1'b0);
    wait_done(bc);
    @(negedge clk);

    // Randomized runs, including empty brackets and back-to-back starts.
    for (int t = 0; t < 24; t++) begin
      c0 = int'($urandom_range(8000)) - 4000;
      c1 = int'($urandom_range(2048)) - 1024;
      c2 = int'($urandom_range(1024)) - 512;
      l  = int'($urandom_range(1536)) - 1280;
      h  = int'($urandom_range(1536)) - 256;
      if ($urandom_range(7) == 0) h = l;
      launch(c0, c1, c2, l, h, 1'b1);
      wait_done(bc);
      if ($urandom_range(1) == 1) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
